spi_cmd_ram: RTL and testbench

//  Command-decoded single-port RAM sitting directly downstream of the SPI slave.

---
 rtl/spi_cmd_ram.sv | 48 ++++
 tb/tb_spi_cmd_ram.sv | 112 +++++++++++
 2 files changed

// File: rtl/spi_cmd_ram.sv
// spi_cmd_ram: command-decoded RAM behind an SPI slave with auto-incrementing write/read pointers
module spi_cmd_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);
  logic [7:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
  logic wr_vld, rd_vld;
  logic [1:0] op;
  logic set_wa, set_ra, do_wr, do_rd, err;
  always_comb begin
    op     = din[9:8];
    set_wa = rx_valid && op == 2'b00;
    set_ra = rx_valid && op == 2'b10;
    do_wr  = rx_valid && op == 2'b01 && wr_vld;
    do_rd  = rx_valid && op == 2'b11 && rd_vld;
    err    = rx_valid && op[0] && !(op[1] ? rd_vld : wr_vld);
  end
  // Memory is deliberately left out of reset so contents survive rst.
  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= din[7:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout     <= '0;
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_vld   <= 1'b0;
      rd_vld   <= 1'b0;
    end else begin
      tx_valid <= do_rd;
      cmd_err  <= err;
      dout     <= do_rd ? mem[rd_ptr] : dout;
      wr_vld   <= wr_vld | set_wa;
      rd_vld   <= rd_vld | set_ra;
      wr_ptr   <= set_wa ? din[ADDR_SIZE-1:0] : do_wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr   <= set_ra ? din[ADDR_SIZE-1:0] : do_rd ? rd_ptr + 1'b1 : rd_ptr;
    end
endmodule

// File: tb/tb_spi_cmd_ram.sv
// tb_spi_cmd_ram: directed self-checking bench for spi_cmd_ram
module tb_spi_cmd_ram;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] dout;
  logic       tx_valid, cmd_err;
  int ntest = 0;
  int nfail = 0;
  spi_cmd_ram dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
    .dout(dout), .tx_valid(tx_valid), .cmd_err(cmd_err)
  );
  always #5 clk = ~clk;
  task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
    din = {op, pl};
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [7:0] dv, input logic tv, input logic ev);
    ntest++;
    if (dout !== dv || tx_valid !== tv || cmd_err !== ev) begin
      nfail++;
      $display("FAIL %s: got dout=%h tx_valid=%b cmd_err=%b, want dout=%h tx_valid=%b cmd_err=%b",
               name, dout, tx_valid, cmd_err, dv, tv, ev);
    end
  endtask
  task automatic test_reset_state;
    idle(2);
    chk("reset_state", 8'h00, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b0;
    idle(1);
    chk("after_release", 8'h00, 1'b0, 1'b0);
  endtask
  task automatic test_unaddressed_read;
    cmd(2'b11, 8'h00);
    chk("rd_no_addr", 8'h00, 1'b0, 1'b1);
    idle(1);
    chk("rd_no_addr_pulse_end", 8'h00, 1'b0, 1'b0);
  endtask
  task automatic test_write_read;
    cmd(2'b00, 8'h10);
    chk("wr_addr", 8'h00, 1'b0, 1'b0);
    cmd(2'b01, 8'hA5);
    chk("wr_data", 8'h00, 1'b0, 1'b0);
    cmd(2'b10, 8'h10);
    chk("rd_addr", 8'h00, 1'b0, 1'b0);
    cmd(2'b11, 8'hFF);
    chk("rd_data", 8'hA5, 1'b1, 1'b0);
    idle(1);
    chk("rd_pulse_one_cycle", 8'hA5, 1'b0, 1'b0);
  endtask
  task automatic test_idle_and_raw;
    din = 10'h3FF;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold", 8'hA5, 1'b0, 1'b0);
    cmd(2'b01, 8'h77);
    chk("raw_write", 8'hA5, 1'b0, 1'b0);
    cmd(2'b11, 8'h00);
    chk("raw_read", 8'h77, 1'b1, 1'b0);
  endtask
  task automatic test_burst_wrap;
    cmd(2'b00, 8'hFE);
    cmd(2'b01, 8'h11);
    cmd(2'b01, 8'h22);
    cmd(2'b01, 8'h33);
    cmd(2'b10, 8'hFE);
    cmd(2'b11, 8'h00);
    chk("burst_fe", 8'h11, 1'b1, 1'b0);
    cmd(2'b11, 8'h00);
    chk("burst_ff", 8'h22, 1'b1, 1'b0);
    cmd(2'b11, 8'h00);
    chk("burst_wrap_00", 8'h33, 1'b1, 1'b0);
  endtask
  task automatic test_reset_midstream_and_error;
    cmd(2'b10, 8'h11);
    cmd(2'b11, 8'h00);
    chk("pre_reset_read", 8'h77, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_reset", 8'h00, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b0;
    cmd(2'b11, 8'h00);
    chk("rd_after_reset", 8'h00, 1'b0, 1'b1);
    cmd(2'b01, 8'h55);
    chk("wr_no_addr", 8'h00, 1'b0, 1'b1);
    cmd(2'b10, 8'h00);
    chk("rd_addr_after_err", 8'h00, 1'b0, 1'b0);
    cmd(2'b11, 8'h00);
    chk("mem0_unchanged", 8'h33, 1'b1, 1'b0);
  endtask
  initial begin
    test_reset_state;
    test_unaddressed_read;
    test_write_read;
    test_idle_and_raw;
    test_burst_wrap;
    test_reset_midstream_and_error;
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
